// File: rtl/ahb_slave_mem.sv
// AHB-lite word memory slave with programmable data-phase wait states,
// pipelined back-to-back transfers and a two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [15:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int AW = $clog2(DEPTH);
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] WS_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_write;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_open;
  logic          w_sample;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic          w_commit;
  logic          w_rd_enter;
  logic [AW-1:0] w_rd_idx;
  logic          w_unused;

  assign w_open   = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_sample = hsel && hready && htrans[1] && w_open;
  assign w_err    = (haddr[1:0] != 2'b00) || (hsize != 3'b010);
  assign w_idx    = haddr[AW+1:2];
  assign w_commit = (r_state == ST_DATA) && r_write;

  // Read data is captured on the edge entering DATA: from WAIT for the held
  // transfer, or straight from the address phase when there are no wait states.
  assign w_rd_enter = ((r_state == ST_WAIT) && (r_cnt == 4'd0) && !r_write) ||
                      (!HAS_WAIT && w_sample && !w_err && !hwrite);
  assign w_rd_idx   = (r_state == ST_WAIT) ? r_idx : w_idx;

  // Address bits above the word index and htrans[0] do not affect this slave.
  assign w_unused = ^{haddr[15:AW+2], htrans[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_write <= 1'b0;
    end else begin
      if (w_sample) begin
        r_idx   <= w_idx;
        r_write <= hwrite;
      end
      case (r_state)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (w_sample) begin
            if (w_err) begin
              r_state <= ST_ERR1;
            end else if (HAS_WAIT) begin
              r_state <= ST_WAIT;
              r_cnt   <= WS_LOAD;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ERR1: r_state <= ST_ERR2;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage is never reset; a write pending when rst rises is dropped because
  // the state has already left DATA.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= hwdata;
    end
    if (w_rd_enter) begin
      r_rdata <= (w_commit && (r_idx == w_rd_idx)) ? hwdata : r_mem[w_rd_idx];
    end
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (r_state)
      ST_WAIT: hreadyout = 1'b0;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  assign hrdata = ((r_state == ST_DATA) && !r_write) ? r_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: three instances (3, 2 and 0 wait states)
// share the bus signals, each selected by its own hsel.
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_en;
  int          sel;

  logic        hsel_a, hsel_b, hsel_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        resp_a, resp_b, resp_c;
  logic [31:0] mux_rdata;
  logic        mux_rdy, mux_resp;
  logic        hready_bus;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign hsel_a = hsel & (sel == 0);
  assign hsel_b = hsel & (sel == 1);
  assign hsel_c = hsel & (sel == 2);

  always_comb begin
    mux_rdata = rd_a;
    mux_rdy   = rdy_a;
    mux_resp  = resp_a;
    case (sel)
      1: begin mux_rdata = rd_b; mux_rdy = rdy_b; mux_resp = resp_b; end
      2: begin mux_rdata = rd_c; mux_rdy = rdy_c; mux_resp = resp_c; end
      default: ;
    endcase
  end

  assign hready_bus = hready_en & mux_rdy;

  ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready_bus),
    .hrdata(rd_a), .hreadyout(rdy_a), .hresp(resp_a));

  ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready_bus),
    .hrdata(rd_b), .hreadyout(rdy_b), .hresp(resp_b));

  ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .hsel(hsel_c), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready_bus),
    .hrdata(rd_c), .hreadyout(rdy_c), .hresp(resp_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [15:0] a, input logic wr, input logic [2:0] sz);
    hsel   = 1'b1;
    haddr  = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
  endtask

  task automatic push_okay(input int ws, input logic [31:0] rd);
    exp_t e;
    for (int i = 0; i < ws; i++) begin
      e.rdy = 1'b0; e.resp = 1'b0; e.rdata = 32'h0;
      exp_q.push_back(e);
    end
    e.rdy = 1'b1; e.resp = 1'b0; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.rdy = 1'b0; e.resp = 1'b1; e.rdata = 32'h0;
    exp_q.push_back(e);
    e.rdy = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    exp_t e;
    e.rdy = 1'b1; e.resp = 1'b0; e.rdata = 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      sel = k;
      @(negedge clk);
      checks++;
      if ({mux_rdy, mux_resp, mux_rdata} !== {1'b1, 1'b0, 32'h0}) begin
        failures++;
        $display("FAIL reset_state dut%0d: got rdy=%b resp=%b rdata=%h, want rdy=1 resp=0 rdata=0",
                 k, mux_rdy, mux_resp, mux_rdata);
      end
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    sel = 0;
    addr_phase(16'h0048, 1'b1, 3'b010); push_okay(3, 32'h0); step();
    bus_idle(); hwdata = 32'h11111111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      e = exp_q.pop_front();
      if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
        failures++;
        $display("FAIL rst_mid_wr[%0d]: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 i, mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
      end
      step();
    end
    // second write to the same word is aborted by reset during its DATA cycle
    addr_phase(16'h0048, 1'b1, 3'b010); step();
    bus_idle(); hwdata = 32'h22222222;
    repeat (3) step();
    @(negedge clk);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    // read aborted by reset while in WAIT
    addr_phase(16'h0048, 1'b0, 3'b010); step();
    bus_idle();
    @(negedge clk);
    checks++;
    if (mux_rdy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_wait: got rdy=%b, want rdy=0", mux_rdy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mux_rdy, mux_resp, mux_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL rst_mid_async: got rdy=%b resp=%b rdata=%h, want rdy=1 resp=0 rdata=0",
               mux_rdy, mux_resp, mux_rdata);
    end
    step();
    rst = 1'b0;
    exp_q.delete();
    addr_phase(16'h0048, 1'b0, 3'b010); push_okay(3, 32'h11111111); step();
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      e = exp_q.pop_front();
      if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
        failures++;
        $display("FAIL rst_mid_rd[%0d]: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 i, mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
      end
      step();
    end
  endtask

  task automatic test_wait_rw();
    exp_t e;
    sel = 1;
    addr_phase(16'h0010, 1'b1, 3'b010); push_okay(2, 32'h0); step();
    bus_idle(); hwdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      e = exp_q.pop_front();
      if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
        failures++;
        $display("FAIL wait_wr[%0d]: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 i, mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
      end
      step();
    end
    addr_phase(16'h0010, 1'b0, 3'b010); push_okay(2, 32'hDEADBEEF); step();
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      e = exp_q.pop_front();
      if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
        failures++;
        $display("FAIL wait_rd[%0d]: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 i, mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sel = 1;
    addr_phase(16'h0030, 1'b1, 3'b010); push_okay(2, 32'h0); step();
    hwdata = 32'h0BADF00D;
    addr_phase(16'h0030, 1'b0, 3'b010); push_okay(2, 32'h0BADF00D);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL b2b[%0d]: got no expectation, want a queued entry", i);
      end else begin
        e = exp_q.pop_front();
        if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
          failures++;
          $display("FAIL b2b[%0d]: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                   i, mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
        end
      end
      step();
      if (i == 2) bus_idle();
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    sel = 1;
    addr_phase(16'h0013, 1'b1, 3'b010); push_err(); push_idle(); step();
    bus_idle(); hwdata = 32'hBADBAD00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      e = exp_q.pop_front();
      if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
        failures++;
        $display("FAIL misalign[%0d]: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 i, mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
      end
      step();
    end
    addr_phase(16'h0010, 1'b0, 3'b010); push_okay(2, 32'hDEADBEEF); step();
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      e = exp_q.pop_front();
      if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
        failures++;
        $display("FAIL misalign_rd[%0d]: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 i, mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
      end
      step();
    end
  endtask

  task automatic test_size_err();
    exp_t e;
    sel = 1;
    addr_phase(16'h0010, 1'b0, 3'b000); push_err(); push_idle(); step();
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      e = exp_q.pop_front();
      if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
        failures++;
        $display("FAIL size_err[%0d]: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 i, mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
      end
      step();
    end
  endtask

  task automatic test_forwarding();
    exp_t e;
    sel = 2;
    addr_phase(16'h0020, 1'b1, 3'b010); push_okay(0, 32'h0); step();
    bus_idle(); hwdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    e = exp_q.pop_front();
    if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
      failures++;
      $display("FAIL fwd_pre: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
               mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
    end
    step();
    addr_phase(16'h0020, 1'b1, 3'b010); push_okay(0, 32'h0); step();
    hwdata = 32'h12345678;
    addr_phase(16'h0020, 1'b0, 3'b010); push_okay(0, 32'h12345678);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      e = exp_q.pop_front();
      if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
        failures++;
        $display("FAIL fwd[%0d]: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 i, mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
      end
      step();
      if (i == 0) bus_idle();
    end
  endtask

  task automatic test_nonsel();
    exp_t e;
    sel = 2;
    for (int c = 0; c < 3; c++) begin
      hsel   = (c != 1);
      haddr  = 16'h0020;
      htrans = (c == 0) ? 2'b01 : 2'b10;
      hwrite = 1'b1;
      hsize  = 3'b010;
      hready_en = (c != 2);
      push_idle(); push_idle();
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        checks++;
        e = exp_q.pop_front();
        if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
          failures++;
          $display("FAIL nonsel%0d[%0d]: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                   c, i, mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
        end
        step();
        if (i == 0) begin
          bus_idle();
          hready_en = 1'b1;
          hwdata = 32'hFFFFFFFF;
        end
      end
    end
    addr_phase(16'h0020, 1'b0, 3'b010); push_okay(0, 32'h12345678); step();
    bus_idle();
    @(negedge clk);
    checks++;
    e = exp_q.pop_front();
    if ({mux_rdy, mux_resp, mux_rdata} !== {e.rdy, e.resp, e.rdata}) begin
      failures++;
      $display("FAIL nonsel_rd: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
               mux_rdy, mux_resp, mux_rdata, e.rdy, e.resp, e.rdata);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    sel = 0;
    hready_en = 1'b1;
    hwdata = 32'h0;
    haddr = 16'h0;
    bus_idle();
    step();
    test_reset();
    test_reset_mid();
    test_wait_rw();
    test_back_to_back();
    test_misaligned();
    test_size_err();
    test_forwarding();
    test_nonsel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-lite word-addressable memory slave that sits directly downstream of the address decoder and read multiplexer. One instance is placed per decoder output (hsel_1/2/3). Each instance returns its hrdata_x/hreadyout_x/hresp_x into the read mux. It supports programmable wait states, pipelined back-to-back transfers, and a two-cycle ERROR response for unsupported accesses.

Parameters:
DEPTH, 256, number of 32-bit words; the word index is haddr[AW+1:2] with AW = clog2(DEPTH).
WAIT_STATES, 0, data-phase wait cycles inserted per accepted OKAY transfer; legal range 0..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
hsel  input  1  slave select from the address decoder
haddr  input  16  byte address
htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
hwrite  input  1  1 = write, 0 = read
hsize  input  3  transfer size; only 3'b010 (word) is supported
hwdata  input  32  write data, valid in the data phase
hready  input  1  global bus ready, i.e. the read-mux hreadyout
hrdata  output  32  read data
hreadyout  output  1  slave ready
hresp  output  1  0 OKAY, 1 ERROR

Behaviour:
- Reset is asynchronous: state=IDLE, hreadyout=1, hresp=0, hrdata=0, and the wait counter is cleared. Memory array is not cleared by reset. Reset asserted mid-transfer aborts the transfer immediately; an in-flight write is not committed.
- Address-phase sample is taken on a rising edge when hsel=1, hready=1, htrans[1]=1, and state is IDLE, DATA or ERR2. The sample registers the word index, hwrite, and an error flag.
- Error condition: haddr[1:0]!=0 or hsize!=3'b010.
- In every other case (hsel=0, htrans IDLE/BUSY, or hready=0 in IDLE/DATA/ERR2):
  - no sample is taken;
  - a completing DATA or ERR2 state returns to IDLE;
  - IDLE holds.
  - A hsel=1 cycle with IDLE/BUSY htrans gets a zero-wait OKAY, i.e. hreadyout=1 and hresp=0 in IDLE.
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
  - WAIT: hreadyout=0, hresp=0. The counter loads WAIT_STATES-1 on entry and decrements. Go to DATA when counter==0.
  - DATA: hreadyout=1, hresp=0. The transfer completes at the end of this cycle.
  - ERR1: hreadyout=0, hresp=1. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1.
- Transitions on a sample:
  - error flag set -> ERR1;
  - else WAIT_STATES>0 -> WAIT;
  - else -> DATA.
- Latency:
  - OKAY data phase lasts WAIT_STATES+1 cycles.
  - ERROR data phase is always 2 cycles.
- Write commit: mem[idx] <= hwdata on the edge that ends DATA for a write. Erroring writes never modify memory.
- Read data:
  - rdata_q loads mem[idx] on the edge that enters DATA for a read.
  - hrdata = rdata_q while in DATA for a read; otherwise hrdata=0.
- Forwarding: when a write completes on the same edge that loads rdata_q for a read to the same index, rdata_q takes hwdata.
- Pipelining: a new sample taken in DATA or ERR2 proceeds with no idle cycle between transfers.

Test Plan:
1. Reset mid-transfer: WAIT_STATES=3, read issued, rst pulsed during WAIT -> same cycle hreadyout=1, hresp=0, hrdata=0, state IDLE; the next transfer behaves normally.
2. Wait-state write/read: WAIT_STATES=2, NONSEQ write haddr=16'h0010, hwdata=32'hDEADBEEF, then NONSEQ read 16'h0010 -> each data phase shows hreadyout=0 for 2 cycles then 1; read data phase shows hrdata=32'hDEADBEEF.
3. Pipelined hazard: WAIT_STATES=0, write 16'h0020=32'h12345678 immediately followed by read 16'h0020 -> no idle cycle; read hrdata=32'h12345678 via forwarding.
4. Misaligned error: write haddr=16'h0013 -> ERR1 (hreadyout=0, hresp=1), ERR2 (hreadyout=1, hresp=1), then IDLE; a later read of 16'h0010 still returns the prior value.
5. Size error: read with hsize=3'b000 at 16'h0010 -> two-cycle ERROR and hrdata=0 throughout.
6. Non-selection: hsel=1 with htrans=BUSY, and hsel=0 with htrans=NONSEQ write, plus a NONSEQ sample with hready=0 -> hreadyout=1, hresp=0, and memory unchanged in all three cases.
